mux_arb_nt1: RTL and testbench

- Parametrised N-to-1 data multiplexer with a registered output stage and per-channel valid/ready handshakes.
- Successor to the fixed 2:1 64-bit combinational mux.
- Two selection modes: static (external select) and round-robin arbitration among requesting channels.
- Sits between multiple producers (e.g. register-file read ports, bus masters) and a single consumer; registers the selected word with its source index.

---
 rtl/mux_arb_nt1_pkg.sv | 17 +
 rtl/mux_arb_nt1_rr.sv | 34 +++
 rtl/mux_arb_nt1.sv | 84 ++++++++
 tb/tb_mux_arb_nt1.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_nt1_pkg.sv
// Shared definitions for the N-to-1 arbitrated multiplexer.
// Mode encodings and a constant clog2 helper for derived widths.
package mux_arb_nt1_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_arb_nt1_rr.sv
// Round-robin priority search: first requester after 'last', wrapping.
// Ports: req (requests), last (previous grant), en -> grant, grant_idx.
module rr_arbiter_n
    import mux_arb_nt1_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx
);

    logic          found;
    logic [SW-1:0] pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int k = 1; k <= N; k++) begin
            pos = SW'((int'(last) + k) % N);
            if (en && !found && req[pos]) begin
                grant[pos] = 1'b1;
                grant_idx  = pos;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nt1.sv
// N-to-1 mux with registered output, static or round-robin selection.
// Ports: in_data/in_valid/in_ready per channel, mode, sel, out_* handshake.
module mux_arb_nt1
    import mux_arb_nt1_pkg::*;
#(
    parameter  int W  = 64,
    parameter  int N  = 4,
    localparam int SW = clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_src,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [SW-1:0] last_grant;
    logic          load_en;
    logic [N-1:0]  grant_s;
    logic [N-1:0]  grant_rr;
    logic [SW-1:0] idx_rr;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;

    assign load_en = !out_valid || out_ready;

    rr_arbiter_n #(.N(N)) u_rr (
        .req       (in_valid),
        .last      (last_grant),
        .en        (mode == MODE_RR),
        .grant     (grant_rr),
        .grant_idx (idx_rr)
    );

    always_comb begin
        grant_s = '0;
        if (int'(sel) < N && in_valid[sel]) begin
            grant_s[sel] = 1'b1;
        end
    end

    assign grant     = (mode == MODE_RR) ? grant_rr : grant_s;
    assign grant_idx = (mode == MODE_RR) ? idx_rr : sel;

    // No grant may complete a handshake while reset is held.
    assign in_ready = grant & {N{load_en && !rst}};

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            last_grant <= SW'(N - 1);
        end else if (load_en) begin
            if (|grant) begin
                out_data  <= grant_data;
                out_src   <= grant_idx;
                out_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    last_grant <= grant_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_nt1.sv
// Self-checking bench for mux_arb_nt1 (W=64, N=4).
// Table-driven rows plus scoreboard of accepted words.
module tb_mux_arb_nt1;

    localparam int W = 64;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_valid;
    logic           out_ready;

    mux_arb_nt1 #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       md;
        logic [1:0] sl;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   src;
    } exp_t;

    vec_t tbl[18];
    exp_t sb[$];
    int   tests;
    int   fails;

    function automatic logic [W-1:0] chdata(input int r, input int i);
        if (r == 8 && i == 2) return 64'h00000000FFFFFFFF;
        return {16'hC0DE, 8'(r), 8'(i), 32'(r * 7 + i)};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one row at the start of the low phase, check mid-phase,
    // then advance to the next falling edge.
    task automatic apply(input int r, input logic md, input logic [1:0] sl,
                         input logic [3:0] vld, input logic ordy,
                         input logic [3:0] rdy, input logic ov);
        exp_t e;
        mode      = md;
        sel       = sl;
        in_valid  = vld;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = chdata(r, i);
        #2;
        chk($sformatf("r%0d out_valid", r), 64'(out_valid), 64'(ov));
        if (ov && ordy) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL r%0d scoreboard empty on drain", r);
            end else begin
                e = sb.pop_front();
                chk($sformatf("r%0d out_data", r), out_data, e.data);
                chk($sformatf("r%0d out_src", r), 64'(out_src), 64'(e.src));
            end
        end else if (ov && sb.size() > 0) begin
            chk($sformatf("r%0d hold_data", r), out_data, sb[0].data);
        end
        chk($sformatf("r%0d in_ready", r), 64'(in_ready), 64'(rdy));
        for (int i = 0; i < N; i++) begin
            if (rdy[i]) begin
                e.data = chdata(r, i);
                e.src  = 2'(i);
                sb.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        mode = 1'b1;
        sel = 2'd0;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        in_data = '0;

        // mode sel valid ordy rdy ov
        tbl[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[5]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1};
        tbl[6]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1};
        tbl[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1};
        tbl[8]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1};
        tbl[9]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b1};
        tbl[10] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0};
        tbl[11] = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b1000, 1'b0};
        tbl[12] = '{1'b1, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[13] = '{1'b1, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[14] = '{1'b1, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[15] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1};
        tbl[16] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1};
        tbl[17] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0};

        // Reset held with every channel requesting.
        @(negedge clk);
        #2;
        chk("rst in_ready", 64'(in_ready), 64'h0);
        chk("rst out_valid", 64'(out_valid), 64'h0);
        chk("rst out_data", out_data, 64'h0);
        chk("rst out_src", 64'(out_src), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 18; r++) begin
            apply(r, tbl[r].md, tbl[r].sl, tbl[r].vld, tbl[r].ordy,
                  tbl[r].rdy, tbl[r].ov);
        end

        // Mid-operation reset: load ch0, stall, then pulse rst.
        apply(20, 1'b1, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b0);
        mode = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b0;
        #2;
        chk("pre_rst out_valid", 64'(out_valid), 64'h1);
        rst = 1'b1;
        #1;
        chk("async out_valid", 64'(out_valid), 64'h0);
        chk("async out_data", out_data, 64'h0);
        chk("async in_ready", 64'(in_ready), 64'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        apply(21, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        apply(22, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1);
        apply(23, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1);
        apply(24, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);

        chk("sb empty", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
